// File: rtl/mult_div_unit.sv
// Iterative signed/unsigned multiply/divide unit (one bit per cycle, HI/LO result pair).
// Optional macro MDU_EARLY_TERM_EN: multiply ends early once the remaining multiplier bits are zero.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] port_a,
  input  logic [WIDTH-1:0] port_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero,
  output logic             zero
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE = 2'b00, CALC = 2'b01, FIX = 2'b10, DONE = 2'b11} state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic             sa_q, sa_d, sb_q, sb_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d, q_q, q_d, mc_q, mc_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             busy_q, busy_d, done_q, done_d, dz_q, dz_d, zero_q, zero_d;

  logic [WIDTH-1:0]   mag_a_s, mag_b_s, acc_step_s, q_step_s, quot_s, rem_s;
  logic [WIDTH:0]     sum_s, shl_s, diff_s;
  logic [2*WIDTH-1:0] prod_s;
  logic               accept_s;

  // acc holds product-high / remainder, q holds multiplier->product-low / dividend->quotient
  always_comb begin
    mag_a_s = (op[0] && port_a[WIDTH-1]) ? -port_a : port_a;
    mag_b_s = (op[0] && port_b[WIDTH-1]) ? -port_b : port_b;
    sum_s   = {1'b0, acc_q} + (q_q[0] ? {1'b0, mc_q} : {(WIDTH+1){1'b0}});
    shl_s   = {acc_q, q_q[WIDTH-1]};
    diff_s  = shl_s - {1'b0, mc_q};
    if (op_q[1]) begin
      acc_step_s = diff_s[WIDTH] ? shl_s[WIDTH-1:0] : diff_s[WIDTH-1:0];
      q_step_s   = {q_q[WIDTH-2:0], ~diff_s[WIDTH]};
    end else begin
      acc_step_s = sum_s[WIDTH:1];
      q_step_s   = {sum_s[0], q_q[WIDTH-1:1]};
    end
`ifdef MDU_EARLY_TERM_EN
    // after an early exit the product still sits cnt_q bits too high
    prod_s = {acc_q, q_q} >> cnt_q;
`else
    prod_s = {acc_q, q_q};
`endif
    if (sa_q ^ sb_q) begin
      prod_s = -prod_s;
      quot_s = -q_q;
    end else begin
      quot_s = q_q;
    end
    rem_s = sa_q ? -acc_q : acc_q;
  end

  // next-state and result-register logic
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    q_d      = q_q;
    mc_d     = mc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dz_d     = dz_q;
    accept_s = start && ((state_q == IDLE) || (state_q == DONE));
    case (state_q)
      IDLE, DONE: begin
        if (accept_s) begin
          op_d  = op;
          sa_d  = op[0] & port_a[WIDTH-1];
          sb_d  = op[0] & port_b[WIDTH-1];
          cnt_d = CW'(WIDTH);
          acc_d = {WIDTH{1'b0}};
          if (op[1]) begin
            q_d  = mag_a_s;
            mc_d = mag_b_s;
          end else begin
            q_d  = mag_b_s;
            mc_d = mag_a_s;
          end
          if (op[1] && (port_b == {WIDTH{1'b0}})) begin
            state_d = DONE;
            hi_d    = port_a;
            lo_d    = {WIDTH{1'b1}};
            dz_d    = 1'b1;
          end else begin
            state_d = CALC;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        acc_d = acc_step_s;
        q_d   = q_step_s;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = FIX;
        end else begin
          state_d = CALC;
        end
`ifdef MDU_EARLY_TERM_EN
        if (!op_q[1] && ((q_step_s & ~({WIDTH{1'b1}} << (cnt_q - CW'(1)))) == {WIDTH{1'b0}})) begin
          state_d = FIX;
        end else begin
          state_d = state_d;
        end
`endif
      end
      FIX: begin
        state_d = DONE;
        dz_d    = 1'b0;
        if (op_q[1]) begin
          hi_d = rem_s;
          lo_d = quot_s;
        end else begin
          hi_d = prod_s[2*WIDTH-1:WIDTH];
          lo_d = prod_s[WIDTH-1:0];
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == CALC) || (state_d == FIX);
    done_d = (state_d == DONE);
    zero_d = (hi_d == {WIDTH{1'b0}}) && (lo_d == {WIDTH{1'b0}});
  end

  // state and registered outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      op_q    <= 2'b00;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      cnt_q   <= {CW{1'b0}};
      acc_q   <= {WIDTH{1'b0}};
      q_q     <= {WIDTH{1'b0}};
      mc_q    <= {WIDTH{1'b0}};
      hi_q    <= {WIDTH{1'b0}};
      lo_q    <= {WIDTH{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      mc_q    <= mc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      zero_q  <= zero_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = dz_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit (WIDTH=32): expectations queued on accept, checked on done.
module tb_mult_div_unit;
  localparam int W = 32;

  logic         CLK, RST, start;
  logic [1:0]   op;
  logic [W-1:0] port_a, port_b;
  logic         busy, done, div_zero, zero;
  logic [W-1:0] hi, lo;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    logic [31:0]  lat;
    logic [31:0]  c0;
  } exp_t;

  exp_t  sb[$];
  string nq[$];
  int    n_total, n_bad, cyc;

  mult_div_unit #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .start(start), .op(op), .port_a(port_a), .port_b(port_b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero), .zero(zero)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference results from plain 64-bit arithmetic.
  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        e;
    logic [63:0] p;
    longint      sa, sbv, qq, rr;
    int          steps;
    logic [W-1:0] mb;
    e = '0;
    e.lat = 32'(W + 2);
    sa  = $signed(a);
    sbv = $signed(b);
    case (o)
      2'b00: p = {32'h0, a} * {32'h0, b};
      2'b01: p = 64'(sa * sbv);
      default: p = 64'h0;
    endcase
    if (o[1]) begin
      if (b == 32'h0) begin
        e.hi = a; e.lo = 32'hFFFF_FFFF; e.dz = 1'b1; e.lat = 32'd1;
      end else if (o[0]) begin
        qq = sa / sbv; rr = sa % sbv;
        e.lo = qq[31:0]; e.hi = rr[31:0];
      end else begin
        e.lo = a / b; e.hi = a % b;
      end
    end else begin
      e.hi = p[63:32]; e.lo = p[31:0];
`ifdef MDU_EARLY_TERM_EN
      mb = (o[0] && b[W-1]) ? (32'h0 - b) : b;
      steps = 1;
      for (int i = 1; i < W; i++) if ((mb >> i) != 32'h0) steps = i + 1;
      e.lat = 32'(steps + 2);
`else
      mb = b; steps = W;
`endif
    end
    return e;
  endfunction

  task automatic issue(input string name, input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   n;
    n = 0;
    @(negedge CLK);
    while (busy && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (busy) begin
      chk({name, ".issue_timeout"}, 64'(busy), 64'd0);
      return;
    end
    start = 1'b1; op = o; port_a = a; port_b = b;
    @(posedge CLK);
    #1;
    start = 1'b0;
    e = model(o, a, b);
    e.c0 = 32'(cyc);
    sb.push_back(e);
    nq.push_back(name);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge CLK);
      n++;
    end
    chk("drain_timeout", 64'(sb.size()), 64'd0);
    @(negedge CLK);
  endtask

  // Output monitor: pops one expectation per done pulse.
  initial begin : mon
    int    busy_run;
    exp_t  e;
    string nm;
    busy_run = 0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        busy_run = 0;
      end else if (done) begin
        if (sb.size() == 0) begin
          chk("spurious_done", 64'(done), 64'd0);
        end else begin
          e  = sb.pop_front();
          nm = nq.pop_front();
          chk({nm, ".lo"}, 64'(lo), 64'(e.lo));
          chk({nm, ".hi"}, 64'(hi), 64'(e.hi));
          chk({nm, ".div_zero"}, 64'(div_zero), 64'(e.dz));
          chk({nm, ".zero"}, 64'(zero), 64'((e.hi == 32'h0) && (e.lo == 32'h0)));
          chk({nm, ".busy_at_done"}, 64'(busy), 64'd0);
          chk({nm, ".latency"}, 64'(cyc - int'(e.c0) + 1), 64'(e.lat));
          chk({nm, ".busy_cycles"}, 64'(busy_run), 64'(e.lat - 32'd1));
        end
        busy_run = 0;
      end else if (busy) begin
        busy_run++;
      end else begin
        busy_run = 0;
      end
    end
  end

  initial begin
    n_total = 0; n_bad = 0; cyc = 0;
    start = 1'b0; op = 2'b00; port_a = '0; port_b = '0;
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.done", 64'(done), 64'd0);
    chk("rst.hi", 64'(hi), 64'd0);
    chk("rst.lo", 64'(lo), 64'd0);
    chk("rst.div_zero", 64'(div_zero), 64'd0);
    chk("rst.zero", 64'(zero), 64'd1);
    RST = 1'b0;

    issue("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue("mult_neg", 2'b01, 32'hFFFF_FFFD, 32'h0000_0007);
    issue("divu_7_2", 2'b10, 32'd7, 32'd2);
    issue("div_neg", 2'b11, 32'hFFFF_FFF9, 32'd2);
    issue("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    issue("divu_zero", 2'b10, 32'd5, 32'd0);
    issue("multu_0x0", 2'b00, 32'd0, 32'd0);
    issue("mult_b0", 2'b01, 32'h1234_5678, 32'd0);

    // a start pulse while busy must be dropped
    issue("div_ign", 2'b11, 32'd1000, 32'hFFFF_FFF9);
    repeat (9) @(negedge CLK);
    start = 1'b1; op = 2'b00; port_a = 32'd1; port_b = 32'd1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    issue("multu_b2b", 2'b00, 32'd2, 32'd3);

    for (int i = 0; i < 10; i++) begin
      logic [1:0]   ro;
      logic [W-1:0] ra, rb;
      ro = 2'($urandom_range(3, 0));
      ra = $urandom();
      rb = ($urandom_range(7, 0) == 0) ? 32'd0 : $urandom();
      issue($sformatf("rnd%0d", i), ro, ra, rb);
    end
    drain();

    // reset mid-divide discards the operation
    issue("div_rst", 2'b10, 32'hDEAD_BEEF, 32'd3);
    repeat (15) @(negedge CLK);
    RST = 1'b1;
    #1;
    chk("midrst.busy", 64'(busy), 64'd0);
    chk("midrst.hi", 64'(hi), 64'd0);
    chk("midrst.lo", 64'(lo), 64'd0);
    chk("midrst.done", 64'(done), 64'd0);
    sb.delete();
    nq.delete();
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    repeat (40) @(negedge CLK);

    issue("multu_after_rst", 2'b00, 32'd2, 32'd3);
    drain();
    repeat (5) @(negedge CLK);
    chk("hold.lo", 64'(lo), 64'd6);
    chk("hold.hi", 64'(hi), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
